// File: rtl/cricket_pkg.sv
// Shared constants, FSM state type and the delivery decoder for the
// delivery_generator slice.
package cricket_pkg;

    localparam logic [3:0] CODE_NOBALL    = 4'd5;
    localparam logic [3:0] CODE_WIDE      = 4'd7;
    localparam int         BALLS_PER_OVER = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_WAIT_REL
    } state_t;

    typedef struct packed {
        logic [2:0] runs;
        logic       is_extra;
        logic       is_wicket;
    } delivery_t;

    function automatic delivery_t decode_delivery(input logic [3:0] code);
        delivery_t d;
        d = '0;
        case (code)
            4'd2, 4'd11, 4'd12:    d.runs = 3'd1;
            4'd3, 4'd13:           d.runs = 3'd2;
            4'd4:                  d.runs = 3'd3;
            4'd6, 4'd14:           d.runs = 3'd4;
            4'd8:                  d.runs = 3'd6;
            4'd9, 4'd15:           d.is_wicket = 1'b1;
            CODE_NOBALL, CODE_WIDE: begin
                d.runs     = 3'd1;
                d.is_extra = 1'b1;
            end
            default:               d.runs = 3'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/delivery_generator_if.sv
// Delivery event bus driven by delivery_generator and consumed by the
// ball counting, scoring and display blocks.
interface delivery_generator_if;

    logic       ball_valid;
    logic [3:0] ball_code;
    logic [2:0] runs;
    logic       is_extra;
    logic       is_wicket;
    logic       free_hit;
    logic [2:0] over_ball;
    logic [4:0] overs;
    logic       over_done;
    logic       innings_full;

    modport master (
        output ball_valid, ball_code, runs, is_extra, is_wicket, free_hit,
               over_ball, overs, over_done, innings_full
    );

    modport slave (
        input  ball_valid, ball_code, runs, is_extra, is_wicket, free_hit,
               over_ball, overs, over_done, innings_full
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter. db follows the synchronised
// button only after DEBOUNCE_CYCLES consecutive equal samples; settled marks
// that db has been qualified at least once since reset.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db,
    output logic settled
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          meta;
    logic          sync;
    logic          prev;
    logic [CW-1:0] cnt;

    // NOTE: every flop here uses <= so all of them see pre-edge values;
    // with = the synchroniser stages would collapse into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            prev    <= 1'b0;
            cnt     <= '0;
            db      <= 1'b0;
            settled <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            prev <= sync;
            if (sync != prev) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db      <= sync;
                settled <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/delivery_generator.sv
// Bowl-button delivery producer: debounce, LFSR sample, decode, over tracking.
// Optional free-hit handling is compiled in with `define FREE_HIT_EN.
module delivery_generator
    import cricket_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [3:0] LFSR_SEED       = 4'b1001,
    parameter int         MAX_OVERS       = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        btn_bowl,
    input  logic                        inning_over,
    input  logic                        game_over,
    delivery_generator_if.master        dlv
);

    localparam logic [3:0] SEED_INIT = (LFSR_SEED == 4'd0) ? 4'b0001 : LFSR_SEED;

    logic      db;
    logic      settled;
    logic      db_q;
    logic      armed;
    logic      io_q;
    logic [3:0] lfsr;
    state_t    state;
    delivery_t dec;
    logic      db_rise;
    logic      io_rise;
    logic      last_ball;
    logic      hit_shield;
    logic      fh_next;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn_bowl),
        .db      (db),
        .settled (settled)
    );

    // armed stays low until a released level is seen, so a button held
    // through reset cannot bowl without being re-pressed.
    assign db_rise   = db & ~db_q & armed;
    assign io_rise   = inning_over & ~io_q;
    assign dec       = decode_delivery(lfsr);
    assign last_ball = (dlv.over_ball == 3'(BALLS_PER_OVER - 1));

`ifdef FREE_HIT_EN
    assign hit_shield = dlv.free_hit & dec.is_wicket;
    assign fh_next    = dec.is_extra & (dlv.free_hit | (lfsr == CODE_NOBALL));
`else
    assign hit_shield = 1'b0;
    assign fh_next    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            lfsr             <= SEED_INIT;
            db_q             <= 1'b0;
            armed            <= 1'b0;
            io_q             <= 1'b0;
            dlv.ball_valid   <= 1'b0;
            dlv.ball_code    <= 4'd0;
            dlv.runs         <= 3'd0;
            dlv.is_extra     <= 1'b0;
            dlv.is_wicket    <= 1'b0;
            dlv.free_hit     <= 1'b0;
            dlv.over_ball    <= 3'd0;
            dlv.overs        <= 5'd0;
            dlv.over_done    <= 1'b0;
            dlv.innings_full <= 1'b0;
        end else begin
            lfsr           <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            db_q           <= db;
            io_q           <= inning_over;
            dlv.ball_valid <= 1'b0;
            dlv.over_done  <= 1'b0;
            if (settled && !db) armed <= 1'b1;

            if (io_rise) begin
                dlv.over_ball    <= 3'd0;
                dlv.overs        <= 5'd0;
                dlv.innings_full <= 1'b0;
                dlv.free_hit     <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (db_rise && !game_over && !dlv.innings_full) state <= S_EMIT;
                end
                S_EMIT: begin
                    state <= S_WAIT_REL;
                    // A delivery meeting the innings-change edge is dropped.
                    if (!io_rise) begin
                        dlv.ball_valid <= 1'b1;
                        dlv.ball_code  <= lfsr;
                        dlv.runs       <= hit_shield ? 3'd0 : dec.runs;
                        dlv.is_extra   <= dec.is_extra;
                        dlv.is_wicket  <= dec.is_wicket & ~hit_shield;
                        dlv.free_hit   <= fh_next;
                        if (!dec.is_extra) begin
                            if (last_ball) begin
                                dlv.over_ball <= 3'd0;
                                dlv.overs     <= dlv.overs + 5'd1;
                                dlv.over_done <= 1'b1;
                                if (dlv.overs == 5'(MAX_OVERS - 1)) dlv.innings_full <= 1'b1;
                            end else begin
                                dlv.over_ball <= dlv.over_ball + 3'd1;
                            end
                        end
                    end
                end
                S_WAIT_REL: begin
                    if (!db) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delivery_generator.sv
// Directed bench for delivery_generator: presses are timed against a local
// LFSR model so each delivery code is chosen by the bench.
module tb_delivery_generator;

    localparam int DB   = 8;
    localparam int MAXO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_bowl = 1'b0;
    logic inning_over = 1'b0;
    logic game_over = 1'b0;

    delivery_generator_if dlv ();

    delivery_generator #(
        .DEBOUNCE_CYCLES (DB),
        .LFSR_SEED       (4'b1001),
        .MAX_OVERS       (MAXO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_bowl    (btn_bowl),
        .inning_over (inning_over),
        .game_over   (game_over),
        .dlv         (dlv)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_valid  = 0;
    int         exp_ob   = 0;
    int         exp_ov   = 0;
    bit         exp_fh   = 1'b0;
    logic [3:0] m_lfsr   = 4'b1001;

    function automatic logic [3:0] lfsr_adv(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) v = {v[2:0], v[3] ^ v[2]};
        return v;
    endfunction

    always @(posedge clk) m_lfsr <= rst ? 4'b1001 : lfsr_adv(m_lfsr, 1);
    always @(posedge clk) if (dlv.ball_valid === 1'b1) n_valid++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_runs(input logic [3:0] c);
        case (c)
            4'd2, 4'd11, 4'd12: return 3'd1;
            4'd3, 4'd13:        return 3'd2;
            4'd4:               return 3'd3;
            4'd6, 4'd14:        return 3'd4;
            4'd8:               return 3'd6;
            4'd5, 4'd7:         return 3'd1;
            default:            return 3'd0;
        endcase
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_over_ball"}, 32'(dlv.over_ball), 32'(exp_ob));
        check({tag, "_overs"}, 32'(dlv.overs), 32'(exp_ov));
        check({tag, "_innings_full"}, 32'(dlv.innings_full), 32'(exp_ov == MAXO));
        check({tag, "_free_hit"}, 32'(dlv.free_hit), 32'(exp_fh));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(dlv.ball_valid), 32'd0);
        check({tag, "_code"}, 32'(dlv.ball_code), 32'd0);
        check({tag, "_runs"}, 32'(dlv.runs), 32'd0);
        check({tag, "_extra"}, 32'(dlv.is_extra), 32'd0);
        check({tag, "_wicket"}, 32'(dlv.is_wicket), 32'd0);
        check({tag, "_over_done"}, 32'(dlv.over_done), 32'd0);
        check_counters(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_ob = 0;
        exp_ov = 0;
        exp_fh = 1'b0;
    endtask

    task automatic align(input logic [3:0] want);
        for (int g = 0; g < 16 && lfsr_adv(m_lfsr, DB + 4) != want; g++) @(negedge clk);
    endtask

    // Press now; the strobe is due DB+5 falling edges later.
    task automatic held_press(input bit expect_valid, input bit raise_io, input bit release_after);
        logic [3:0] code;
        bit         wkt;
        bit         extra;
        bit         od;
        int         base;
        code  = lfsr_adv(m_lfsr, DB + 4);
        base  = n_valid;
        wkt   = (code == 4'd9) || (code == 4'd15);
        extra = (code == 4'd5) || (code == 4'd7);
        btn_bowl = 1'b1;
        for (int i = 1; i <= DB + 5; i++) begin
            @(negedge clk);
            if (raise_io && i == DB + 4) inning_over = 1'b1;
        end
        check("strobe", 32'(dlv.ball_valid), 32'(expect_valid));
        if (raise_io) begin
            exp_ob = 0;
            exp_ov = 0;
            exp_fh = 1'b0;
            check_counters("discard");
        end else if (expect_valid) begin
            od = 1'b0;
            check("ball_code", 32'(dlv.ball_code), 32'(code));
            check("runs", 32'(dlv.runs), 32'(ref_runs(code)));
            check("is_extra", 32'(dlv.is_extra), 32'(extra));
            check("is_wicket", 32'(dlv.is_wicket), 32'(wkt && !exp_fh));
            if (extra) begin
`ifdef FREE_HIT_EN
                if (code == 4'd5) exp_fh = 1'b1;
`endif
            end else begin
                exp_fh = 1'b0;
                exp_ob++;
                if (exp_ob == 6) begin
                    exp_ob = 0;
                    exp_ov++;
                    od = 1'b1;
                end
            end
            check("over_done", 32'(dlv.over_done), 32'(od));
            check_counters("ball");
        end
        @(negedge clk);
        check("pulse_valid", 32'(dlv.ball_valid), 32'd0);
        check("pulse_over_done", 32'(dlv.over_done), 32'd0);
        if (release_after) begin
            btn_bowl = 1'b0;
            repeat (DB + 8) @(negedge clk);
            check("strobe_count", 32'(n_valid - base), 32'(expect_valid));
        end
    endtask

    task automatic bowl(input logic [3:0] want, input bit expect_valid, input bit raise_io);
        align(want);
        held_press(expect_valid, raise_io, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int guard;

        // Reset state and seed.
        do_reset();
        check_all_zero("reset");
        check("lfsr_seed", 32'(dut.lfsr), 32'd9);
        repeat (DB + 6) @(negedge clk);

        // Bounce below the debounce window, then hold.
        base = n_valid;
        for (int i = 0; i < 10; i++) begin
            btn_bowl = ~btn_bowl;
            repeat (2) @(negedge clk);
        end
        check("bounce_quiet", 32'(n_valid - base), 32'd0);
        held_press(1'b1, 1'b0, 1'b1);

        // Six legal balls complete one over.
        do_reset();
        repeat (DB + 6) @(negedge clk);
        for (int i = 0; i < 6; i++) bowl(4'd2, 1'b1, 1'b0);
        check("over1_overs", 32'(dlv.overs), 32'd1);

        // No-ball, wide, then a wicket code.
        bowl(4'd5, 1'b1, 1'b0);
        bowl(4'd7, 1'b1, 1'b0);
        bowl(4'd9, 1'b1, 1'b0);

        // Run the innings to the last ball.
        guard = 0;
        while (!(exp_ov == MAXO - 1 && exp_ob == 5) && guard < 200) begin
            bowl(4'd4, 1'b1, 1'b0);
            guard++;
        end
        bowl(4'd1, 1'b1, 1'b0);
        check("full_flag", 32'(dlv.innings_full), 32'd1);
        bowl(4'd4, 1'b0, 1'b0);

        // Innings change clears the counters.
        inning_over = 1'b1;
        repeat (2) @(negedge clk);
        exp_ob = 0;
        exp_ov = 0;
        exp_fh = 1'b0;
        check_counters("inning_over");
        inning_over = 1'b0;
        repeat (2) @(negedge clk);

        // Delivery coinciding with the innings-change edge is dropped.
        bowl(4'd2, 1'b1, 1'b0);
        bowl(4'd3, 1'b0, 1'b1);
        inning_over = 1'b0;
        repeat (2) @(negedge clk);

        // game_over blocks new deliveries.
        game_over = 1'b1;
        bowl(4'd3, 1'b0, 1'b0);
        game_over = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while waiting for release with the button held.
        align(4'd6);
        held_press(1'b1, 1'b0, 1'b0);
        do_reset();
        check_all_zero("rst_held");
        base = n_valid;
        repeat (3 * DB + 20) @(negedge clk);
        check("held_after_rst", 32'(n_valid - base), 32'd0);
        btn_bowl = 1'b0;
        repeat (DB + 8) @(negedge clk);
        check("release_after_rst", 32'(n_valid - base), 32'd0);
        bowl(4'd8, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
